sr_latch_bank: RTL
==================

# sr_latch_bank

Parametrised, clocked successor to the single SR latch: a bank of CHANNELS independent set/reset state bits, each with an optional input synchroniser, a selectable resolution mode for simultaneous set and reset, and shared conflict monitoring. It sits between asynchronous or foreign-domain control strobes and the synchronous control logic of the design. It replaces ad-hoc cross-coupled latches with a registered, glitch-free, reset-defined store.

## Interface
- CHANNELS, 8, number of independent SR channels (1..32)
- MODE, 0, resolution when S and R are both active: 0 reset-dominant, 1 set-dominant, 2 toggle (JK), 3 hold
- SYNC_STAGES, 2, flip-flop stages on every s/r bit before use (0..3; 0 = inputs used directly)
- CNT_W, 8, width of saturating conflict counter (≥ 2)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s  in  CHANNELS  per-channel set request, level-sensitive
- r  in  CHANNELS  per-channel reset request, level-sensitive
- clr  in  1  synchronous clear of all state bits, conflict flags and counter
- q  out  CHANNELS  stored state
- qbar  out  CHANNELS  always exactly ~q (no forbidden q = qbar state exists)
- conflict  out  CHANNELS  registered, one cycle per cycle that channel's synchronised s and r are both 1
- conflict_any  out  1  sticky: set on any conflict, cleared only by clr or reset
- conflict_cnt  out  CNT_W  saturating total count of channel-conflict events

## Operation
- Synchronised inputs ss[i], rs[i] = s[i], r[i] delayed through SYNC_STAGES flops (sync flops reset to 0).
- Per channel, next q: ss=0,rs=0 hold; ss=1,rs=0 → 1; ss=0,rs=1 → 0; ss=1,rs=1 → per MODE (0: 0, 1: 1, 2: ~q, 3: hold).
- conflict[i] next = ss[i] & rs[i], in every MODE (toggle mode still reports it).
- conflict_cnt next = min(conflict_cnt + popcount(ss & rs), 2^CNT_W − 1); the add is done at CNT_W+6 bits then saturated, so multiple channels in one cycle add their full count.
- conflict_any next = conflict_any | (|(ss & rs)).
- clr=1: next q = 0, conflict = 0, conflict_cnt = 0, conflict_any = 0, regardless of ss/rs that cycle; sync flops are not cleared by clr and keep shifting.
- Reset values: q = 0, qbar = all ones, conflict = 0, conflict_any = 0, conflict_cnt = 0, all sync flops 0. Reset asserted mid-operation clears everything immediately (asynchronously); first update after rst_n rises uses sync-flop contents, which are 0, so q holds 0 for SYNC_STAGES cycles minimum.
- Illegal parameters (MODE > 3, SYNC_STAGES > 3, CHANNELS outside range) are caught by elaboration-time assertion.

## Timing
- Latency s/r pin to q/conflict: SYNC_STAGES + 1 rising edges; to conflict_cnt/conflict_any: same edge as conflict.
- Pulse on s or r shorter than one clock period may be missed when SYNC_STAGES > 0; pulses ≥ 1 clock are always captured.
- Toggle mode with s=r=1 held: q toggles every cycle.
- Counter at 2^CNT_W − 1 stays there; clr on the same cycle as a conflict leaves counter 0.
- All outputs are registered; qbar is the inverted q register, no combinational path from inputs to outputs.

## Structure
- Package sr_pkg: MODE constants (SR_MODE_RST_DOM, SR_MODE_SET_DOM, SR_MODE_TOGGLE, SR_MODE_HOLD) and limits (SR_MAX_SYNC = 3, SR_MAX_CHANNELS = 32).
- Sub-module sr_sync: one-bit, SYNC_STAGES-deep synchroniser with async active-low reset, instantiated 2×CHANNELS times via generate; pass-through when SYNC_STAGES = 0.
- Top contains per-channel next-state logic, popcount, saturating adder and sticky flag.

## Test plan
- Reset then s[0] = 1 for one cycle, SYNC_STAGES=2 → q[0] = 1 exactly 3 edges later, qbar[0] = 0, other channels 0.
- MODE=0, s[3]=r[3]=1 held 4 cycles → q[3] = 0, conflict[3] high 4 cycles, conflict_cnt = 4, conflict_any = 1; repeat MODE=1 → q[3] = 1; MODE=3 with q[3] preset 1 → stays 1.
- MODE=2, q[1]=0, s[1]=r[1]=1 held 3 cycles → q[1] sequence 1,0,1; conflict_cnt = 3.
- CNT_W=2, all 8 channels s=r=1 for one cycle → conflict_cnt = 3 (saturated), stays 3 on further conflicts; then clr → cnt 0, conflict_any 0, q all 0.
- clr asserted on same cycle as s[2]=1 reaches logic → q[2] = 0 that edge, becomes 1 next edge if s still held.
- rst_n dropped asynchronously between edges with q = 0xFF → q = 0x00, qbar = 0xFF immediately; after release, q stays 0 until new s propagates.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared constants and helpers for the clocked SR latch bank.
package sr_pkg;

  localparam int unsigned SR_MODE_RST_DOM  = 0;
  localparam int unsigned SR_MODE_SET_DOM  = 1;
  localparam int unsigned SR_MODE_TOGGLE   = 2;
  localparam int unsigned SR_MODE_HOLD     = 3;

  localparam int unsigned SR_MAX_SYNC      = 3;
  localparam int unsigned SR_MAX_CHANNELS  = 32;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Control-strobe and state bus of the SR latch bank.
interface sr_latch_bank_if #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned CNT_W    = 8
);
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] r;
    logic                clr;
    logic [CHANNELS-1:0] q;
    logic [CHANNELS-1:0] qbar;
    logic [CHANNELS-1:0] conflict;
    logic                conflict_any;
    logic [CNT_W-1:0]    conflict_cnt;

    modport master (
        output s, r, clr,
        input  q, qbar, conflict, conflict_any, conflict_cnt
    );

    modport slave (
        input  s, r, clr,
        output q, qbar, conflict, conflict_any, conflict_cnt
    );
endinterface

// File: rtl/sr_sync.sv
// One-bit synchroniser of STAGES flops; a plain wire when STAGES is 0.
module sr_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    if (STAGES == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_chain
        logic [STAGES-1:0] chain_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q <= '0;
            end else begin
                chain_q[0] <= din;
                for (int i = 1; i < STAGES; i++) begin
                    chain_q[i] <= chain_q[i-1];
                end
            end
        end

        assign dout = chain_q[STAGES-1];
    end
endmodule

// File: rtl/sr_latch_bank.sv
// Bank of registered SR state bits with input synchronisers, selectable
// simultaneous-S/R resolution and shared conflict monitoring.
module sr_latch_bank
    import sr_pkg::*;
#(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned MODE        = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    sr_latch_bank_if.slave  bus
);
    localparam int unsigned SumW = CNT_W + 6;

    if (MODE > SR_MODE_HOLD || SYNC_STAGES > SR_MAX_SYNC || CHANNELS < 1 ||
        CHANNELS > SR_MAX_CHANNELS || CNT_W < 2) begin : g_param_err
        $fatal(1, "sr_latch_bank: illegal parameter combination");
    end

    logic [CHANNELS-1:0] ss;
    logic [CHANNELS-1:0] rs;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sr_sync #(.STAGES(SYNC_STAGES)) u_sync_s (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (bus.s[i]),
            .dout (ss[i])
        );
        sr_sync #(.STAGES(SYNC_STAGES)) u_sync_r (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (bus.r[i]),
            .dout (rs[i])
        );
    end

    logic [CHANNELS-1:0] state_q, state_d;
    logic [CHANNELS-1:0] conflict_q, conflict_d;
    logic                any_q, any_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] both;
    logic [SumW-1:0]     sum;

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < CHANNELS; i++) begin
            case ({ss[i], rs[i]})
                2'b10: state_d[i] = 1'b1;
                2'b01: state_d[i] = 1'b0;
                2'b11: begin
                    case (MODE)
                        SR_MODE_RST_DOM: state_d[i] = 1'b0;
                        SR_MODE_SET_DOM: state_d[i] = 1'b1;
                        SR_MODE_TOGGLE:  state_d[i] = ~state_q[i];
                        default:         state_d[i] = state_q[i];
                    endcase
                end
                default: state_d[i] = state_q[i];
            endcase
        end

        both       = ss & rs;
        conflict_d = both;
        any_d      = any_q | (|both);
        // Wide add so several channels conflicting together all count before saturating.
        sum        = SumW'(cnt_q) + SumW'(popcount32(32'(both)));
        cnt_d      = (sum > SumW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

        if (bus.clr) begin
            state_d    = '0;
            conflict_d = '0;
            any_d      = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= '0;
            conflict_q <= '0;
            any_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            conflict_q <= conflict_d;
            any_q      <= any_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.q            = state_q;
    assign bus.qbar         = ~state_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_any = any_q;
    assign bus.conflict_cnt = cnt_q;
endmodule
